adc_read_sequencer: RTL
=======================

ADC_READ_SEQUENCER -- requirements
Module: adc_read_sequencer

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 2, log2 of samples averaged per output (range 0..4).
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waited for DRDY after DEN.
REQ-003 SHALL have port CLK  in  1  the single clock for all logic.
REQ-004 SHALL have port RESET_N  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port ENABLE  in  1  high = run conversion reads.
REQ-006 SHALL have port CHANNEL  in  5  XADC channel number, captured on EOC.
REQ-007 SHALL have port EOC  in  1  XADC end-of-conversion pulse.
REQ-008 SHALL have port DRDY  in  1  XADC DRP read-data strobe.
REQ-009 SHALL have port DO  in  16  DRP read data; result in DO[15:4].
REQ-010 SHALL have port DEN  out  1  DRP enable, single-cycle pulse.
REQ-011 SHALL have port DADDR  out  7  DRP address, {2'b00, captured CHANNEL}.
REQ-012 SHALL have port DWE  out  1  DRP write enable, constant 0.
REQ-013 SHALL have port SAMPLE  out  12  averaged voltage code.
REQ-014 SHALL have port SAMPLE_VALID  out  1  SAMPLE holds a new result.
REQ-015 SHALL have port SAMPLE_READY  in  1  consumer accepts SAMPLE.
REQ-016 SHALL have port TIMEOUT_ERR  out  1  sticky: DRDY never arrived.
REQ-017 SHALL have port OVERRUN  out  1  sticky: EOC arrived while holding an unaccepted result.

Function
REQ-018 SHALL implement states IDLE, WAIT_EOC, READ, WAIT_DRDY, HOLD.
REQ-019 IDLE: ENABLE=1 -> WAIT_EOC next cycle; accumulator and sample count cleared.
REQ-020 WAIT_EOC: EOC=1 -> capture CHANNEL into DADDR, go READ; ENABLE=0 -> IDLE.
REQ-021 READ: DEN=1 for exactly this one cycle, then WAIT_DRDY; watchdog count cleared.
REQ-022 WAIT_DRDY: DRDY=1 -> add DO[15:4] to accumulator (width 12+AVG_LOG2, no overflow possible), increment count.
REQ-023 On DRDY, if count reaches 2^AVG_LOG2 -> SAMPLE = accumulator >> AVG_LOG2 (truncate), SAMPLE_VALID=1 next cycle, go HOLD, clear accumulator/count; else return WAIT_EOC (or IDLE if ENABLE=0, discarding partial sum).
REQ-024 WAIT_DRDY: watchdog reaching TIMEOUT without DRDY -> TIMEOUT_ERR=1, partial sum discarded, go WAIT_EOC (IDLE if ENABLE=0).
REQ-025 ENABLE falling during WAIT_DRDY SHALL NOT abort the DRP transaction; the state completes (DRDY or timeout) first.
REQ-026 HOLD: SAMPLE and SAMPLE_VALID stable until SAMPLE_READY=1; the handshake cycle clears SAMPLE_VALID next cycle and goes WAIT_EOC (IDLE if ENABLE=0).
REQ-027 EOC in HOLD (not the handshake cycle) SHALL be ignored and set OVERRUN; EOC coincident with the handshake cycle SHALL also be ignored without setting OVERRUN.
REQ-028 EOC in READ or WAIT_DRDY SHALL be ignored (no queuing).
REQ-029 DRDY outside WAIT_DRDY SHALL be ignored.
REQ-030 Result latency from final DRDY to SAMPLE_VALID SHALL be 1 cycle.
REQ-031 SAMPLE_VALID MAY remain high with ENABLE=0 until accepted.

Reset
REQ-032 RESET_N=0 at a CLK edge SHALL force IDLE, DEN=0, DADDR=0, SAMPLE=0, SAMPLE_VALID=0, TIMEOUT_ERR=0, OVERRUN=0, accumulator/count/watchdog=0.
REQ-033 Reset mid-transaction SHALL abandon it; a late DRDY after reset SHALL be ignored.
REQ-034 TIMEOUT_ERR and OVERRUN SHALL clear only by reset.

Structure
REQ-035 State encoding and DRP address width constant SHALL live in shared package sp_pkg.
REQ-036 The DRDY watchdog SHALL be sub-module drdy_watchdog (clear, enable, expired).

Verification
REQ-037 AVG_LOG2=2, four EOC/DRDY reads with DO[15:4]=100,101,102,103 -> SAMPLE=101, SAMPLE_VALID one cycle after 4th DRDY.
REQ-038 EOC with CHANNEL=5'h10 -> DADDR=7'h10, DEN high exactly 1 cycle, DWE=0 always.
REQ-039 No DRDY for 255 cycles after DEN -> TIMEOUT_ERR=1, next EOC starts fresh average (4 new reads needed).
REQ-040 SAMPLE_READY held 0, EOC pulsed -> SAMPLE unchanged, OVERRUN=1; then SAMPLE_READY=1 -> SAMPLE_VALID=0 next cycle.
REQ-041 ENABLE dropped after 2 of 4 reads, raised later -> partial sum discarded; 4 reads of 4095 -> SAMPLE=4095.
REQ-042 RESET_N=0 during WAIT_DRDY, DRDY pulsed after release -> all outputs 0, state IDLE, no accumulation.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared definitions for the XADC read sequencer: FSM state encoding,
// DRP field widths and the DRP address builder.
package sp_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int CH_W       = 5;
  localparam int RES_W      = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_EOC  = 3'd1,
    ST_READ      = 3'd2,
    ST_WAIT_DRDY = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  // XADC status registers sit at the channel number itself, upper bits zero.
  function automatic logic [DRP_ADDR_W-1:0] drp_addr(input logic [CH_W-1:0] ch);
    return {{(DRP_ADDR_W-CH_W){1'b0}}, ch};
  endfunction

endpackage

// File: rtl/drdy_watchdog.sv
// Cycle counter that flags a DRP read whose DRDY has not arrived within
// TIMEOUT cycles of waiting.
module drdy_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // Count waiting cycles; saturate at the limit so expiry stays asserted.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  // Expires on the TIMEOUT-th enabled cycle without a clear.
  assign expired_o = enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/adc_read_sequencer.sv
// Waits for XADC end-of-conversion, reads the channel result over DRP,
// averages 2^AVG_LOG2 reads and offers the average on a valid/ready port.
module adc_read_sequencer
  import sp_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic [CH_W-1:0]       CHANNEL,
  input  logic                  EOC,
  input  logic                  DRDY,
  input  logic [15:0]           DO,
  output logic                  DEN,
  output logic [DRP_ADDR_W-1:0] DADDR,
  output logic                  DWE,
  output logic [RES_W-1:0]      SAMPLE,
  output logic                  SAMPLE_VALID,
  input  logic                  SAMPLE_READY,
  output logic                  TIMEOUT_ERR,
  output logic                  OVERRUN
);

  localparam int AW = RES_W + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] NSAMP = CW'(2 ** AVG_LOG2);

  state_t           state_q;
  logic [CH_W-1:0]  ch_q;
  logic             den_q;
  logic [RES_W-1:0] sample_q;
  logic             sample_valid_q;
  logic             timeout_err_q;
  logic             overrun_q;
  logic [AW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;

  logic [AW-1:0]    acc_d;
  logic [CW-1:0]    cnt_d;
  logic             wd_expired_s;
  state_t           resume_s;
  logic             do_lsb_unused;

  // The low nibble of DO carries no result bits for a 12-bit XADC code.
  assign do_lsb_unused = ^DO[3:0];

  assign acc_d    = acc_q + AW'(DO[15:4]);
  assign cnt_d    = cnt_q + CW'(1);
  assign resume_s = ENABLE ? ST_WAIT_EOC : ST_IDLE;

  drdy_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .clear_i   (state_q == ST_READ),
    .enable_i  (state_q == ST_WAIT_DRDY),
    .expired_o (wd_expired_s)
  );

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q        <= ST_IDLE;
      ch_q           <= '0;
      den_q          <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      overrun_q      <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
    end else begin
      den_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          acc_q <= '0;
          cnt_q <= '0;
          if (ENABLE) begin
            state_q <= ST_WAIT_EOC;
          end
        end
        ST_WAIT_EOC: begin
          if (!ENABLE) begin
            state_q <= ST_IDLE;
          end else if (EOC) begin
            ch_q    <= CHANNEL;
            den_q   <= 1'b1;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          state_q <= ST_WAIT_DRDY;
        end
        ST_WAIT_DRDY: begin
          // A disable here only takes effect once the DRP read has completed.
          if (DRDY) begin
            if (cnt_d == NSAMP) begin
              sample_q       <= RES_W'(acc_d >> AVG_LOG2);
              sample_valid_q <= 1'b1;
              acc_q          <= '0;
              cnt_q          <= '0;
              state_q        <= ST_HOLD;
            end else if (ENABLE) begin
              acc_q   <= acc_d;
              cnt_q   <= cnt_d;
              state_q <= ST_WAIT_EOC;
            end else begin
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end
          end else if (wd_expired_s) begin
            timeout_err_q <= 1'b1;
            acc_q         <= '0;
            cnt_q         <= '0;
            state_q       <= resume_s;
          end
        end
        ST_HOLD: begin
          if (SAMPLE_READY) begin
            sample_valid_q <= 1'b0;
            state_q        <= resume_s;
          end else if (EOC) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign DEN          = den_q;
  assign DADDR        = drp_addr(ch_q);
  assign DWE          = 1'b0;
  assign SAMPLE       = sample_q;
  assign SAMPLE_VALID = sample_valid_q;
  assign TIMEOUT_ERR  = timeout_err_q;
  assign OVERRUN      = overrun_q;

endmodule
